divider_arbiter: RTL

- Shares one iterative `divider` instance among N_REQ requesters, for example per-ball centroid x/y normalisation in the juggling tracker.
- Round-robin arbitration with a single outstanding divide.
- Operands are latched on grant, issued to the divider, and the result is routed back with a one-hot response strobe.
- Divide-by-zero is short-circuited locally and never reaches the divider.

---
 rtl/divider_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/divider_arbiter.sv
// Round-robin arbiter sharing one iterative divider among N_REQ requesters.
// One divide outstanding at a time; divide-by-zero is answered locally.
// Optional watchdog: define DIVIDER_ARBITER_TIMEOUT_EN to abort a divide that
// never returns and to expose timeout_count_out.
module divider_arbiter #(
  parameter int N_REQ   = 4,
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic [N_REQ-1:0]       req_valid_in,
  input  logic [N_REQ*WIDTH-1:0] req_dividend_in,
  input  logic [N_REQ*WIDTH-1:0] req_divisor_in,
  output logic [N_REQ-1:0]       req_ready_out,
  output logic [N_REQ-1:0]       resp_valid_out,
  output logic [WIDTH-1:0]       resp_quotient_out,
  output logic [WIDTH-1:0]       resp_remainder_out,
  output logic                   resp_error_out,
  output logic                   busy_out,
  output logic [WIDTH-1:0]       div_dividend_out,
  output logic [WIDTH-1:0]       div_divisor_out,
  output logic                   div_valid_out,
  input  logic [WIDTH-1:0]       div_quotient_in,
  input  logic [WIDTH-1:0]       div_remainder_in,
  input  logic                   div_valid_in,
  input  logic                   div_busy_in
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
  ,
  output logic [15:0]            timeout_count_out
`endif
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 2 || TIMEOUT < 1) begin : g_bad_cfg
    $error("divider_arbiter: N_REQ must be >= 2 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_grant_q, last_grant_d;
  logic [IW-1:0]     grant_q, grant_d;
  logic [WIDTH-1:0]  dividend_q, dividend_d;
  logic [WIDTH-1:0]  divisor_q, divisor_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              err_q, err_d;

`ifdef DIVIDER_ARBITER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0]     wait_cnt_q, wait_cnt_d;
  logic [15:0]       tmo_cnt_q, tmo_cnt_d;
  assign timeout_count_out = tmo_cnt_q;
`endif

  logic [WIDTH-1:0]  dvd_arr [N_REQ];
  logic [WIDTH-1:0]  dvs_arr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign dvd_arr[g] = req_dividend_in[g*WIDTH +: WIDTH];
    assign dvs_arr[g] = req_divisor_in[g*WIDTH +: WIDTH];
  end

  logic              win_found;
  logic [IW-1:0]     win_idx;
  logic [IW-1:0]     cand;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IW'((32'(last_grant_q) + k) % N_REQ);
      if (!win_found && req_valid_in[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Handshake and response strobes; ready is masked during reset so it reads 0.
  always_comb begin
    req_ready_out  = '0;
    resp_valid_out = '0;
    if (state_q == IDLE && rst_n_in && win_found) req_ready_out[win_idx] = 1'b1;
    if (state_q == RESPOND) resp_valid_out[grant_q] = 1'b1;
  end

  assign busy_out           = (state_q != IDLE);
  assign div_valid_out      = (state_q == ISSUE) && !div_busy_in;
  assign div_dividend_out   = dividend_q;
  assign div_divisor_out    = divisor_q;
  assign resp_quotient_out  = quot_q;
  assign resp_remainder_out = rem_q;
  assign resp_error_out     = err_q;

  // Next-state and datapath update logic.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    dividend_d   = dividend_q;
    divisor_d    = divisor_q;
    quot_d       = quot_q;
    rem_d        = rem_q;
    err_d        = err_q;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
    tmo_cnt_d    = tmo_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (win_found) begin
          grant_d      = win_idx;
          last_grant_d = win_idx;
          dividend_d   = dvd_arr[win_idx];
          divisor_d    = dvs_arr[win_idx];
          if (dvs_arr[win_idx] == '0) begin
            quot_d  = '1;
            rem_d   = dvd_arr[win_idx];
            err_d   = 1'b1;
            state_d = RESPOND;
          end else begin
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (!div_busy_in) begin
          state_d = WAIT;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
          wait_cnt_d = '0;
`endif
        end
      end
      WAIT: begin
        if (div_valid_in) begin
          quot_d  = div_quotient_in;
          rem_d   = div_remainder_in;
          err_d   = 1'b0;
          state_d = RESPOND;
        end
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
        else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
          quot_d  = '0;
          rem_d   = '0;
          err_d   = 1'b1;
          state_d = RESPOND;
          if (tmo_cnt_q != '1) tmo_cnt_d = tmo_cnt_q + 16'd1;
        end else begin
          wait_cnt_d = wait_cnt_q + TW'(1);
        end
`endif
      end
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state_q      <= IDLE;
      last_grant_q <= IW'(N_REQ - 1);
      grant_q      <= '0;
      dividend_q   <= '0;
      divisor_q    <= '0;
      quot_q       <= '0;
      rem_q        <= '0;
      err_q        <= 1'b0;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
      wait_cnt_q   <= '0;
      tmo_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      dividend_q   <= dividend_d;
      divisor_q    <= divisor_d;
      quot_q       <= quot_d;
      rem_q        <= rem_d;
      err_q        <= err_d;
`ifdef DIVIDER_ARBITER_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
      tmo_cnt_q    <= tmo_cnt_d;
`endif
    end
  end

endmodule
